// File: rtl/ghost_mover_if.sv
// ghost_mover_if: wall lookup handshake between the ghost mover and the maze wall table.
//   wall_req  : lookup request, held until wall_ack (driven by master)
//   wall_x/y  : coordinate being queried, stable while wall_req is high (driven by master)
//   wall_ack  : one-cycle pulse, lookup result valid (driven by slave)
//   wall_hit  : 1 = queried position is a wall, qualified by wall_ack (driven by slave)
interface ghost_mover_if;
    logic       wall_req;
    logic [9:0] wall_x;
    logic [9:0] wall_y;
    logic       wall_ack;
    logic       wall_hit;

    modport master (
        output wall_req,
        output wall_x,
        output wall_y,
        input  wall_ack,
        input  wall_hit
    );

    modport slave (
        input  wall_req,
        input  wall_x,
        input  wall_y,
        output wall_ack,
        output wall_hit
    );
endinterface

// File: rtl/ghost_mover.sv
// ghost_mover: moves one ghost by STEP pixels per frame tick, in the direction supplied by the
// random direction generator, after checking the candidate square against the maze wall table.
// If the new direction is blocked the current heading is tried instead; if that is blocked too
// the ghost stays put and 'stalled' is raised.
//
// Ports:
//   Clk, Reset  : system clock, asynchronous active-high reset
//   enable      : movement enabled (low = ghost frozen)
//   frame_tick  : one-cycle pulse per frame, starts a move
//   dir         : direction keycode (0x04 left, 0x07 right, 0x16 down, 0x1A up)
//   wall        : wall lookup handshake (master side)
//   pos_x/pos_y : ghost position in pixels
//   heading     : current direction keycode
//   busy        : move in progress
//   moved       : one-cycle pulse in the cycle the new position appears
//   stalled     : both candidate and fallback blocked; cleared by the next successful move
//   overrun     : sticky, frame_tick arrived while busy
module ghost_mover #(
    parameter logic [9:0] START_X = 10'd320,
    parameter logic [9:0] START_Y = 10'd240,
    parameter logic [9:0] X_MAX   = 10'd639,
    parameter logic [9:0] Y_MAX   = 10'd479,
    parameter logic [3:0] STEP    = 4'd1,
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          enable,
    input  logic          frame_tick,
    input  logic [7:0]    dir,
    ghost_mover_if.master wall,
    output logic [9:0]    pos_x,
    output logic [9:0]    pos_y,
    output logic [7:0]    heading,
    output logic          busy,
    output logic          moved,
    output logic          stalled,
    output logic          overrun
);

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StQuery,
        StRetryCalc,
        StRetryQuery,
        StCommit
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d;
    logic [9:0] pos_y_q, pos_y_d;
    logic [7:0] heading_q, heading_d;
    logic [7:0] try_dir_q, try_dir_d;   // direction under test (candidate, then heading)
    logic [9:0] tgt_x_q, tgt_x_d;
    logic [9:0] tgt_y_q, tgt_y_d;
    logic [7:0] wait_q, wait_d;         // query cycles spent without an ack
    logic       moved_q, moved_d;
    logic       stalled_q, stalled_d;
    logic       overrun_q, overrun_d;

    logic              dir_legal;
    logic              blocked;
    logic signed [10:0] step_s;
    logic signed [10:0] delta_x, delta_y;
    logic signed [10:0] next_x, next_y;
    logic [9:0]        calc_x;
    logic              y_bad;

    assign dir_legal = (dir == KEY_LEFT) || (dir == KEY_RIGHT) ||
                       (dir == KEY_DOWN) || (dir == KEY_UP);

    assign step_s = $signed({7'd0, STEP});

    // Target computation from the registered position and the direction under test.
    always_comb begin
        delta_x = '0;
        delta_y = '0;
        case (try_dir_q)
            KEY_LEFT:  delta_x = -step_s;
            KEY_RIGHT: delta_x = step_s;
            KEY_UP:    delta_y = -step_s;
            KEY_DOWN:  delta_y = step_s;
            default:   ;
        endcase
        next_x = $signed({1'b0, pos_x_q}) + delta_x;
        next_y = $signed({1'b0, pos_y_q}) + delta_y;
        // Horizontal tunnel: leaving one side re-enters on the other.
        if (next_x < 11'sd0) begin
            calc_x = X_MAX;
        end else if (next_x > $signed({1'b0, X_MAX})) begin
            calc_x = '0;
        end else begin
            calc_x = next_x[9:0];
        end
        // No vertical tunnel: off-screen rows behave like walls without a lookup.
        y_bad = (next_y < 11'sd0) || (next_y > $signed({1'b0, Y_MAX}));
    end

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        heading_d = heading_q;
        try_dir_d = try_dir_q;
        tgt_x_d   = tgt_x_q;
        tgt_y_d   = tgt_y_q;
        wait_d    = wait_q;
        moved_d   = 1'b0;
        stalled_d = stalled_q;
        overrun_d = overrun_q;
        blocked   = 1'b0;

        // Ticks are never queued; any tick outside IDLE is lost and flagged.
        if (frame_tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_tick && enable) begin
                    try_dir_d = dir_legal ? dir : heading_q;
                    state_d   = StCalc;
                end
            end
            StCalc, StRetryCalc: begin
                tgt_x_d = calc_x;
                tgt_y_d = next_y[9:0];
                wait_d  = '0;
                if (y_bad) begin
                    blocked = 1'b1;
                end else begin
                    state_d = (state_q == StCalc) ? StQuery : StRetryQuery;
                end
            end
            StQuery, StRetryQuery: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (wall.wall_ack) begin
                    if (wall.wall_hit) begin
                        blocked = 1'b1;
                    end else begin
                        state_d = StCommit;
                    end
                end else if (wait_q == TIMEOUT - 8'd1) begin
                    blocked = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StCommit: begin
                pos_x_d   = tgt_x_q;
                pos_y_d   = tgt_y_q;
                heading_d = try_dir_q;
                moved_d   = 1'b1;
                stalled_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Blocked on the first attempt with a new direction: fall back to the heading.
        if (blocked) begin
            if (((state_q == StCalc) || (state_q == StQuery)) && (try_dir_q != heading_q)) begin
                try_dir_d = heading_q;
                state_d   = StRetryCalc;
            end else begin
                stalled_d = 1'b1;
                state_d   = StIdle;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            pos_x_q   <= START_X;
            pos_y_q   <= START_Y;
            heading_q <= KEY_LEFT;
            try_dir_q <= KEY_LEFT;
            tgt_x_q   <= START_X;
            tgt_y_q   <= START_Y;
            wait_q    <= '0;
            moved_q   <= 1'b0;
            stalled_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            heading_q <= heading_d;
            try_dir_q <= try_dir_d;
            tgt_x_q   <= tgt_x_d;
            tgt_y_q   <= tgt_y_d;
            wait_q    <= wait_d;
            moved_q   <= moved_d;
            stalled_q <= stalled_d;
            overrun_q <= overrun_d;
        end
    end

    // Request is a pure function of state, so an async reset drops it immediately.
    assign wall.wall_req = (state_q == StQuery) || (state_q == StRetryQuery);
    assign wall.wall_x   = tgt_x_q;
    assign wall.wall_y   = tgt_y_q;

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign heading = heading_q;
    assign busy    = (state_q != StIdle);
    assign moved   = moved_q;
    assign stalled = stalled_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover: self-checking bench for ghost_mover. A responder process plays the maze wall
// table; each test pushes the requests it expects (coordinate, ack delay, hit) into a scoreboard
// queue, and the responder pops and compares them as the DUT issues requests.
module tb_ghost_mover;

    logic       Clk;
    logic       Reset;
    logic       enable;
    logic       frame_tick;
    logic [7:0] dir;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [7:0] heading;
    logic       busy;
    logic       moved;
    logic       stalled;
    logic       overrun;

    ghost_mover_if wall_bus ();

    ghost_mover dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .dir        (dir),
        .wall       (wall_bus),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .heading    (heading),
        .busy       (busy),
        .moved      (moved),
        .stalled    (stalled),
        .overrun    (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard of expected wall requests; wait < 0 means the ack is withheld.
    int exp_x_q[$];
    int exp_y_q[$];
    int exp_w_q[$];
    bit exp_h_q[$];

    task automatic push_req(input int x, input int y, input int w, input bit h);
        exp_x_q.push_back(x);
        exp_y_q.push_back(y);
        exp_w_q.push_back(w);
        exp_h_q.push_back(h);
    endtask

    task automatic responder();
        int ex, ey, w, guard;
        bit h;
        forever begin
            @(negedge Clk);
            if (wall_bus.wall_req === 1'b1) begin
                n_cmp++;
                if (exp_x_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_req: got request at (%0d,%0d), required none",
                             wall_bus.wall_x, wall_bus.wall_y);
                    w = -1;
                end else begin
                    ex = exp_x_q.pop_front();
                    ey = exp_y_q.pop_front();
                    w  = exp_w_q.pop_front();
                    h  = exp_h_q.pop_front();
                    if ({wall_bus.wall_x, wall_bus.wall_y} !== {ex[9:0], ey[9:0]}) begin
                        n_bad++;
                        $display("FAIL req_xy: got (%0d,%0d), required (%0d,%0d)",
                                 wall_bus.wall_x, wall_bus.wall_y, ex, ey);
                    end
                end
                if (w >= 0) begin
                    repeat (w) @(negedge Clk);
                    wall_bus.wall_ack = 1'b1;
                    wall_bus.wall_hit = h;
                    @(negedge Clk);
                    wall_bus.wall_ack = 1'b0;
                    wall_bus.wall_hit = 1'b0;
                end
                guard = 0;
                while (wall_bus.wall_req === 1'b1 && guard < 100) begin
                    @(negedge Clk);
                    guard++;
                end
                if (guard >= 100) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_stuck: got wall_req=1 for 100 cycles, required release");
                end
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Pulse frame_tick with direction d; idx = cycles from the tick cycle (0) to return to IDLE.
    task automatic run_move(input logic [7:0] d, output int idx, output logic mv,
                            output logic st);
        frame_tick = 1'b1;
        dir        = d;
        @(negedge Clk);
        frame_tick = 1'b0;
        idx = 1;
        while (busy === 1'b1 && idx < 80) begin
            @(negedge Clk);
            idx++;
        end
        mv = moved;
        st = stalled;
    endtask

    task automatic test_reset();
        int guard;
        n_cmp++;
        if ({pos_x, pos_y, heading} !== {10'd320, 10'd240, 8'h04}) begin
            n_bad++;
            $display("FAIL reset_pos: got (%0d,%0d) h=%h, required (320,240) h=04",
                     pos_x, pos_y, heading);
        end
        n_cmp++;
        if ({wall_bus.wall_req, busy, moved, stalled, overrun} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got req/busy/mv/st/ov=%b, required 00000",
                     {wall_bus.wall_req, busy, moved, stalled, overrun});
        end
        Reset = 1'b0;
        // Reset in the middle of a query with the ack withheld.
        push_req(319, 240, -1, 1'b0);
        frame_tick = 1'b1;
        dir        = 8'h04;
        @(negedge Clk);
        frame_tick = 1'b0;
        guard = 0;
        while (wall_bus.wall_req !== 1'b1 && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        n_cmp++;
        if (wall_bus.wall_req !== 1'b1) begin
            n_bad++;
            $display("FAIL midq_req: got wall_req=%b, required 1", wall_bus.wall_req);
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({wall_bus.wall_req, busy, stalled, overrun} !== 4'b0) begin
            n_bad++;
            $display("FAIL midq_flags: got req/busy/st/ov=%b, required 0000",
                     {wall_bus.wall_req, busy, stalled, overrun});
        end
        n_cmp++;
        if ({pos_x, pos_y, heading} !== {10'd320, 10'd240, 8'h04}) begin
            n_bad++;
            $display("FAIL midq_pos: got (%0d,%0d) h=%h, required (320,240) h=04",
                     pos_x, pos_y, heading);
        end
        @(negedge Clk);
        Reset = 1'b0;
        // Stray ack with no request outstanding.
        wall_bus.wall_ack = 1'b1;
        wall_bus.wall_hit = 1'b0;
        @(negedge Clk);
        wall_bus.wall_ack = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({busy, moved, pos_x, pos_y} !== {1'b0, 1'b0, 10'd320, 10'd240}) begin
            n_bad++;
            $display("FAIL stray_ack: got busy=%b mv=%b (%0d,%0d), required 0 0 (320,240)",
                     busy, moved, pos_x, pos_y);
        end
    endtask

    task automatic test_basic_move();
        int idx;
        logic mv, st;
        push_req(321, 240, 0, 1'b0);
        run_move(8'h07, idx, mv, st);
        n_cmp++;
        if (idx != 4 || mv !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_latency: got idx=%0d mv=%b, required 4 1", idx, mv);
        end
        n_cmp++;
        if ({pos_x, pos_y, heading} !== {10'd321, 10'd240, 8'h07}) begin
            n_bad++;
            $display("FAIL basic_pos: got (%0d,%0d) h=%h, required (321,240) h=07",
                     pos_x, pos_y, heading);
        end
        @(negedge Clk);
        n_cmp++;
        if (moved !== 1'b0 || exp_x_q.size() != 0) begin
            n_bad++;
            $display("FAIL basic_pulse: got mv=%b pending=%0d, required 0 0",
                     moved, exp_x_q.size());
        end
    endtask

    task automatic test_retry();
        int idx;
        logic mv, st;
        do_reset();
        push_req(319, 240, 0, 1'b0);
        run_move(8'h04, idx, mv, st);
        push_req(320, 240, 0, 1'b0);
        run_move(8'h07, idx, mv, st);
        // Up is blocked, fallback to heading right succeeds.
        push_req(320, 239, 0, 1'b1);
        push_req(321, 240, 0, 1'b0);
        run_move(8'h1A, idx, mv, st);
        n_cmp++;
        if (idx != 6 || mv !== 1'b1 || st !== 1'b0) begin
            n_bad++;
            $display("FAIL retry_latency: got idx=%0d mv=%b st=%b, required 6 1 0", idx, mv, st);
        end
        n_cmp++;
        if ({pos_x, pos_y, heading} !== {10'd321, 10'd240, 8'h07} || exp_x_q.size() != 0) begin
            n_bad++;
            $display("FAIL retry_pos: got (%0d,%0d) h=%h pending=%0d, required (321,240) h=07 0",
                     pos_x, pos_y, heading, exp_x_q.size());
        end
    endtask

    task automatic test_stall();
        int idx;
        logic mv, st;
        push_req(321, 241, 0, 1'b1);
        push_req(322, 240, 0, 1'b1);
        run_move(8'h16, idx, mv, st);
        n_cmp++;
        if (idx != 5 || mv !== 1'b0 || st !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_flags: got idx=%0d mv=%b st=%b, required 5 0 1", idx, mv, st);
        end
        n_cmp++;
        if ({pos_x, pos_y, heading} !== {10'd321, 10'd240, 8'h07}) begin
            n_bad++;
            $display("FAIL stall_pos: got (%0d,%0d) h=%h, required (321,240) h=07",
                     pos_x, pos_y, heading);
        end
        // Illegal keycode falls back to the heading; the successful move clears stalled.
        push_req(322, 240, 0, 1'b0);
        run_move(8'h55, idx, mv, st);
        n_cmp++;
        if (idx != 4 || mv !== 1'b1 || st !== 1'b0 ||
            {pos_x, pos_y, heading} !== {10'd322, 10'd240, 8'h07}) begin
            n_bad++;
            $display("FAIL stall_clear: got idx=%0d mv=%b st=%b (%0d,%0d) h=%h, required 4 1 0 (322,240) h=07",
                     idx, mv, st, pos_x, pos_y, heading);
        end
    endtask

    task automatic test_wait_and_timeout();
        int idx;
        logic mv, st;
        push_req(322, 241, 2, 1'b0);
        run_move(8'h16, idx, mv, st);
        n_cmp++;
        if (idx != 6 || {pos_x, pos_y, heading} !== {10'd322, 10'd241, 8'h16}) begin
            n_bad++;
            $display("FAIL wait2: got idx=%0d (%0d,%0d) h=%h, required 6 (322,241) h=16",
                     idx, pos_x, pos_y, heading);
        end
        // Ack on the 16th query cycle is still accepted.
        push_req(321, 241, 15, 1'b0);
        run_move(8'h04, idx, mv, st);
        n_cmp++;
        if (idx != 19 || mv !== 1'b1 || {pos_x, pos_y, heading} !== {10'd321, 10'd241, 8'h04}) begin
            n_bad++;
            $display("FAIL wait15: got idx=%0d mv=%b (%0d,%0d) h=%h, required 19 1 (321,241) h=04",
                     idx, mv, pos_x, pos_y, heading);
        end
        // Both queries time out.
        push_req(321, 240, -1, 1'b0);
        push_req(320, 241, -1, 1'b0);
        run_move(8'h1A, idx, mv, st);
        n_cmp++;
        if (idx != 35 || mv !== 1'b0 || st !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_retry: got idx=%0d mv=%b st=%b, required 35 0 1", idx, mv, st);
        end
        // Timeout with candidate equal to heading: no retry.
        push_req(320, 241, -1, 1'b0);
        run_move(8'h04, idx, mv, st);
        n_cmp++;
        if (idx != 18 || st !== 1'b1 || {pos_x, pos_y, heading} !== {10'd321, 10'd241, 8'h04} ||
            exp_x_q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_same: got idx=%0d st=%b (%0d,%0d) h=%h pending=%0d, required 18 1 (321,241) h=04 0",
                     idx, st, pos_x, pos_y, heading, exp_x_q.size());
        end
    endtask

    task automatic test_enable();
        int idx;
        logic mv, st;
        enable = 1'b0;
        run_move(8'h07, idx, mv, st);
        repeat (4) @(negedge Clk);
        n_cmp++;
        if (idx != 1 || busy !== 1'b0 || {pos_x, pos_y} !== {10'd321, 10'd241}) begin
            n_bad++;
            $display("FAIL enable_off: got idx=%0d busy=%b (%0d,%0d), required 1 0 (321,241)",
                     idx, busy, pos_x, pos_y);
        end
        enable = 1'b1;
    endtask

    task automatic test_overrun();
        int idx, guard;
        logic mv, st;
        do_reset();
        // Tick landing in the COMMIT cycle, as the block returns to IDLE.
        push_req(321, 240, 0, 1'b0);
        frame_tick = 1'b1;
        dir        = 8'h07;
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        n_cmp++;
        if ({moved, overrun, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL overrun_edge: got mv/ov/busy=%b, required 110", {moved, overrun, busy});
        end
        repeat (4) @(negedge Clk);
        n_cmp++;
        if (busy !== 1'b0 || {pos_x, pos_y} !== {10'd321, 10'd240}) begin
            n_bad++;
            $display("FAIL overrun_drop: got busy=%b (%0d,%0d), required 0 (321,240)",
                     busy, pos_x, pos_y);
        end
        do_reset();
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_reset: got %b, required 0", overrun);
        end
        // Second tick mid-query.
        push_req(321, 240, 3, 1'b0);
        frame_tick = 1'b1;
        dir        = 8'h07;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        frame_tick = 1'b1;
        dir        = 8'h1A;
        @(negedge Clk);
        frame_tick = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        n_cmp++;
        if (overrun !== 1'b1 || {pos_x, pos_y, heading} !== {10'd321, 10'd240, 8'h07}) begin
            n_bad++;
            $display("FAIL overrun_busy: got ov=%b (%0d,%0d) h=%h, required 1 (321,240) h=07",
                     overrun, pos_x, pos_y, heading);
        end
        push_req(322, 240, 0, 1'b0);
        run_move(8'h07, idx, mv, st);
        n_cmp++;
        if (overrun !== 1'b1 || mv !== 1'b1 || exp_x_q.size() != 0) begin
            n_bad++;
            $display("FAIL overrun_sticky: got ov=%b mv=%b pending=%0d, required 1 1 0",
                     overrun, mv, exp_x_q.size());
        end
    endtask

    task automatic test_wrap_edges();
        int idx;
        logic mv, st;
        do_reset();
        for (int i = 0; i < 320; i++) begin
            push_req(319 - i, 240, 0, 1'b0);
            run_move(8'h04, idx, mv, st);
        end
        for (int i = 0; i < 40; i++) begin
            push_req(0, 239 - i, 0, 1'b0);
            run_move(8'h1A, idx, mv, st);
        end
        n_cmp++;
        if ({pos_x, pos_y} !== {10'd0, 10'd200}) begin
            n_bad++;
            $display("FAIL walk_pos: got (%0d,%0d), required (0,200)", pos_x, pos_y);
        end
        push_req(639, 200, 0, 1'b0);
        run_move(8'h04, idx, mv, st);
        n_cmp++;
        if (mv !== 1'b1 || {pos_x, pos_y, heading} !== {10'd639, 10'd200, 8'h04}) begin
            n_bad++;
            $display("FAIL wrap_left: got mv=%b (%0d,%0d) h=%h, required 1 (639,200) h=04",
                     mv, pos_x, pos_y, heading);
        end
        push_req(0, 200, 0, 1'b0);
        run_move(8'h07, idx, mv, st);
        n_cmp++;
        if (mv !== 1'b1 || {pos_x, pos_y, heading} !== {10'd0, 10'd200, 8'h07}) begin
            n_bad++;
            $display("FAIL wrap_right: got mv=%b (%0d,%0d) h=%h, required 1 (0,200) h=07",
                     mv, pos_x, pos_y, heading);
        end
        for (int i = 0; i < 200; i++) begin
            push_req(0, 199 - i, 0, 1'b0);
            run_move(8'h1A, idx, mv, st);
        end
        // Top row, moving up with heading up: blocked without a lookup.
        run_move(8'h1A, idx, mv, st);
        n_cmp++;
        if (idx != 2 || mv !== 1'b0 || st !== 1'b1) begin
            n_bad++;
            $display("FAIL top_edge: got idx=%0d mv=%b st=%b, required 2 0 1", idx, mv, st);
        end
        n_cmp++;
        if ({pos_x, pos_y, heading} !== {10'd0, 10'd0, 8'h1A} || exp_x_q.size() != 0) begin
            n_bad++;
            $display("FAIL top_pos: got (%0d,%0d) h=%h pending=%0d, required (0,0) h=1a 0",
                     pos_x, pos_y, heading, exp_x_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset             = 1'b0;
        enable            = 1'b1;
        frame_tick        = 1'b0;
        dir               = 8'h00;
        wall_bus.wall_ack = 1'b0;
        wall_bus.wall_hit = 1'b0;
        #2;
        Reset = 1'b1;
        fork
            responder();
        join_none
        repeat (2) @(negedge Clk);
        test_reset();
        test_basic_move();
        test_retry();
        test_stall();
        test_wait_and_timeout();
        test_enable();
        test_overrun();
        test_wrap_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
